// File: rtl/odo_div_pkg.sv
// Shared types and defaults for the odd/even divider scheduler.
package odo_div_pkg;

  localparam int CW      = 4;
  localparam int DEF_DIV = 9;
  localparam int MIN_DIV = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } state_t;

  // Number of posedge cycles the phase level stays high in one period.
  function automatic logic [CW-1:0] half(input logic [CW-1:0] n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/odo_div_phase_cnt.sv
// Period counter: counts 0..N-1, flags the terminal count and decodes
// the phase level for the value the counter is about to take.
module odo_div_phase_cnt
  import odo_div_pkg::*;
#(
  parameter int CW_P = odo_div_pkg::CW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            count_en,
  input  logic            clr,
  input  logic [CW_P-1:0] ratio,
  input  logic [CW_P-1:0] ratio_next,
  output logic [CW_P-1:0] cnt_next,
  output logic            terminal,
  output logic            pos_next
);

  logic [CW_P-1:0] cnt;

  // Next count: hold at zero when cleared, otherwise wrap at N-1.
  always_comb begin
    terminal = (cnt == (ratio - CW_P'(1)));
    cnt_next = cnt;
    if (clr) begin
      cnt_next = '0;
    end else if (count_en) begin
      cnt_next = terminal ? '0 : cnt + CW_P'(1);
    end
    // The ratio that will be active alongside cnt_next sets the high time.
    pos_next = (cnt_next < CW_P'(half(CW'(ratio_next))));
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/odo_div_sched.sv
// Scheduler for the odd/even clock divider: owns the active ratio, a
// one-deep pending ratio slot and the run/stop state. Ratio changes take
// effect only at a period boundary so the divided clock never glitches.
module odo_div_sched
  import odo_div_pkg::*;
#(
  parameter int CW_P      = odo_div_pkg::CW,
  parameter int DEF_DIV_P = odo_div_pkg::DEF_DIV,
  parameter int MIN_DIV_P = odo_div_pkg::MIN_DIV
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            cfg_valid,
  input  logic [CW_P-1:0] cfg_div,
  output logic            cfg_ready,
  output logic            cfg_err,
  output logic            div_pos,
  output logic            div_odd,
  output logic            tick,
  output logic            busy,
  output logic [CW_P-1:0] div_cur
);

  localparam logic [CW_P-1:0] DEF_N = CW_P'(DEF_DIV_P);
  localparam logic [CW_P-1:0] MIN_N = CW_P'(MIN_DIV_P);

  state_t          state, state_next;
  logic [CW_P-1:0] ratio, ratio_next;
  logic [CW_P-1:0] pend_div, pend_div_next;
  logic            pend_valid, pend_valid_next;
  logic [CW_P-1:0] cnt_next;
  logic            terminal, pos_next;
  logic            accept, legal, wrap, running_next;

  odo_div_phase_cnt #(.CW_P(CW_P)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .count_en   (state != IDLE),
    .clr        (state == IDLE),
    .ratio      (ratio),
    .ratio_next (ratio_next),
    .cnt_next   (cnt_next),
    .terminal   (terminal),
    .pos_next   (pos_next)
  );

  // Next-state, ratio and pending-slot decisions for this cycle.
  always_comb begin
    accept          = cfg_valid && cfg_ready;
    legal           = (cfg_div >= MIN_N);
    wrap            = (state != IDLE) && terminal;
    state_next      = state;
    ratio_next      = ratio;
    pend_valid_next = pend_valid;
    pend_div_next   = pend_div;

    case (state)
      IDLE:      state_next = enable ? RUN : IDLE;
      RUN:       state_next = enable ? RUN : STOP_PEND;
      STOP_PEND: state_next = enable ? RUN : (terminal ? IDLE : STOP_PEND);
      default:   state_next = IDLE;
    endcase

    // Only a request stored before this boundary may take effect here.
    if (wrap && pend_valid) begin
      ratio_next      = pend_div;
      pend_valid_next = 1'b0;
    end

    // Idle has no period in flight, so a legal ratio applies directly.
    if (accept && legal) begin
      if (state == IDLE) begin
        ratio_next = cfg_div;
      end else begin
        pend_valid_next = 1'b1;
        pend_div_next   = cfg_div;
      end
    end

    running_next = (state_next != IDLE);
  end

  // State, ratio storage and registered outputs aligned with the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ratio      <= DEF_N;
      pend_valid <= 1'b0;
      pend_div   <= '0;
      div_pos    <= 1'b0;
      div_odd    <= DEF_N[0];
      tick       <= 1'b0;
      busy       <= 1'b0;
      cfg_ready  <= 1'b1;
      cfg_err    <= 1'b0;
      div_cur    <= DEF_N;
    end else begin
      state      <= state_next;
      ratio      <= ratio_next;
      pend_valid <= pend_valid_next;
      pend_div   <= pend_div_next;
      div_pos    <= running_next && pos_next;
      div_odd    <= ratio_next[0];
      tick       <= running_next && (cnt_next == '0);
      busy       <= running_next;
      cfg_ready  <= !pend_valid_next;
      cfg_err    <= accept && !legal;
      div_cur    <= ratio_next;
    end
  end

endmodule
